// File: rtl/systolic_ctrl.sv
// Controller for a 4x4 systolic multiply array: operand buffers, skewed feed, row readout.
// Optional completed-job counter enabled by defining SYSCTRL_JOBCNT_EN.
module systolic_ctrl (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    input  logic        a_wr_en,
    input  logic [3:0]  a_wr_addr,
    input  logic [7:0]  a_wr_data,
    input  logic        b_wr_en,
    input  logic [3:0]  b_wr_addr,
    input  logic [7:0]  b_wr_data,
    output logic [7:0]  a1in,
    output logic [7:0]  a2in,
    output logic [7:0]  a3in,
    output logic [7:0]  a4in,
    output logic [7:0]  b1in,
    output logic [7:0]  b2in,
    output logic [7:0]  b3in,
    output logic [7:0]  b4in,
    output logic        input_en,
    output logic        output_en,
    output logic        arr_rst_b,
    input  logic [63:0] accout,
    output logic        busy,
    output logic        done,
    output logic        row_valid,
    output logic [1:0]  row_idx,
    output logic [63:0] row_data,
    output logic [15:0] job_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        phase_q, phase_d;
    logic [15:0][7:0]  a_buf_q, a_buf_d;
    logic [15:0][7:0]  b_buf_q, b_buf_d;
    logic [3:0][7:0]   a_feed_q, a_feed_d;
    logic [3:0][7:0]   b_feed_q, b_feed_d;
    logic              input_en_q, input_en_d;
    logic              output_en_q, output_en_d;
    logic              arr_rst_b_q, arr_rst_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              row_valid_q, row_valid_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [63:0]       row_data_q, row_data_d;

    // Next-state and phase-counter sequencing.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    phase_d = 4'd0;
                end else begin
                    phase_d = 4'd0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_FEED;
                phase_d = 4'd0;
            end
            ST_FEED: begin
                if (phase_q == 4'd9) begin
                    state_d = ST_READ;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_READ: begin
                if (phase_q == 4'd3) begin
                    state_d = ST_DONE;
                    phase_d = 4'd0;
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 4'd0;
            end
        endcase
    end

    // Operand buffer writes, accepted only while idle.
    always_comb begin
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        if (a_wr_en && (state_q == ST_IDLE)) begin
            a_buf_d[a_wr_addr] = a_wr_data;
        end else begin
            a_buf_d = a_buf_q;
        end
        if (b_wr_en && (state_q == ST_IDLE)) begin
            b_buf_d[b_wr_addr] = b_wr_data;
        end else begin
            b_buf_d = b_buf_q;
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    // Row i of A and column j of B enter skewed by i (j) cycles.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        input_en_d  = (state_d == ST_FEED);
        output_en_d = (state_d == ST_READ);
        arr_rst_b_d = (state_d != ST_CLEAR);
        done_d      = (state_d == ST_DONE);
        for (int i = 0; i < 4; i++) begin
            a_feed_d[i] = 8'h00;
            b_feed_d[i] = 8'h00;
            if ((state_d == ST_FEED) && (phase_d >= 4'(i)) && ((phase_d - 4'(i)) <= 4'd3)) begin
                a_feed_d[i] = a_buf_q[{2'(i), 2'(phase_d - 4'(i))}];
                b_feed_d[i] = b_buf_q[{2'(phase_d - 4'(i)), 2'(i)}];
            end else begin
                a_feed_d[i] = 8'h00;
                b_feed_d[i] = 8'h00;
            end
        end
    end

    // The array presents row r during READ cycle r; capture it at the end of that cycle.
    always_comb begin
        row_valid_d = 1'b0;
        row_idx_d   = row_idx_q;
        row_data_d  = row_data_q;
        if (state_q == ST_READ) begin
            row_valid_d = 1'b1;
            row_idx_d   = phase_q[1:0];
            row_data_d  = accout;
        end else begin
            row_valid_d = 1'b0;
        end
    end

    // Controller state, buffers and registered outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            phase_q     <= 4'd0;
            a_buf_q     <= '0;
            b_buf_q     <= '0;
            a_feed_q    <= '0;
            b_feed_q    <= '0;
            input_en_q  <= 1'b0;
            output_en_q <= 1'b0;
            arr_rst_b_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= 2'd0;
            row_data_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            a_buf_q     <= a_buf_d;
            b_buf_q     <= b_buf_d;
            a_feed_q    <= a_feed_d;
            b_feed_q    <= b_feed_d;
            input_en_q  <= input_en_d;
            output_en_q <= output_en_d;
            arr_rst_b_q <= arr_rst_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
            row_data_q  <= row_data_d;
        end
    end

`ifdef SYSCTRL_JOBCNT_EN
    logic [15:0] job_cnt_q, job_cnt_d;

    // Saturating count of jobs, bumped as the done pulse is registered.
    always_comb begin
        job_cnt_d = job_cnt_q;
        if (done_d && (job_cnt_q != 16'hFFFF)) begin
            job_cnt_d = job_cnt_q + 16'd1;
        end else begin
            job_cnt_d = job_cnt_q;
        end
    end

    // Job counter register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            job_cnt_q <= 16'd0;
        end else begin
            job_cnt_q <= job_cnt_d;
        end
    end

    assign job_cnt = job_cnt_q;
`else
    assign job_cnt = 16'h0000;
`endif

    assign a1in      = a_feed_q[0];
    assign a2in      = a_feed_q[1];
    assign a3in      = a_feed_q[2];
    assign a4in      = a_feed_q[3];
    assign b1in      = b_feed_q[0];
    assign b2in      = b_feed_q[1];
    assign b3in      = b_feed_q[2];
    assign b4in      = b_feed_q[3];
    assign input_en  = input_en_q;
    assign output_en = output_en_q;
    assign arr_rst_b = arr_rst_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign row_valid = row_valid_q;
    assign row_idx   = row_idx_q;
    assign row_data  = row_data_q;

endmodule
